// File: rtl/aes128_encrypt_if.sv
// aes128_encrypt_if: request/result bundle between an AES-128 client and the encryptor
interface aes128_encrypt_if;
  logic start;
  logic [127:0] message;
  logic [127:0] key;
  logic [127:0] cipher;
  logic busy;
  logic done;
  modport master (output start, message, key, input cipher, busy, done);
  modport slave (input start, message, key, output cipher, busy, done);
endinterface

// File: rtl/aes128_encrypt.sv
// aes128_encrypt: iterative FIPS-197 AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes128_encrypt (
  input logic clk,
  input logic rst,
  aes128_encrypt_if.slave bus
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [127:0] r_state, r_key, r_cipher;
  logic [3:0] r_round;
  logic r_busy, r_done;
  logic [127:0] w_sr, w_mc, w_nk;
  logic [31:0] w_t;
  logic [7:0] w_rcon;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] a);
    return {xt(a[31:24]) ^ xt(a[23:16]) ^ a[23:16] ^ a[15:8] ^ a[7:0],
            a[31:24] ^ xt(a[23:16]) ^ xt(a[15:8]) ^ a[15:8] ^ a[7:0],
            a[31:24] ^ a[23:16] ^ xt(a[15:8]) ^ xt(a[7:0]) ^ a[7:0],
            xt(a[31:24]) ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ xt(a[7:0])};
  endfunction
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int k = 0; k < 16; k++) w_sr[127-8*k -: 8] = sb(r_state[127-8*(4*((k/4+k%4)%4)+k%4) -: 8]);
    for (int c = 0; c < 4; c++) w_mc[127-32*c -: 32] = mix(w_sr[127-32*c -: 32]);
  end
  assign w_rcon = r_round == 4'd9 ? 8'h1b : r_round == 4'd10 ? 8'h36 : 8'h01 << (r_round - 4'd1);
  assign w_t = {sb(r_key[23:16]) ^ w_rcon, sb(r_key[15:8]), sb(r_key[7:0]), sb(r_key[31:24])};
  assign w_nk = {r_key[127:96] ^ w_t,
                 r_key[127:96] ^ r_key[95:64] ^ w_t,
                 r_key[127:96] ^ r_key[95:64] ^ r_key[63:32] ^ w_t,
                 r_key[127:96] ^ r_key[95:64] ^ r_key[63:32] ^ r_key[31:0] ^ w_t};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_key <= '0;
      r_cipher <= '0;
      r_round <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (bus.start) begin
          r_state <= bus.message ^ bus.key;
          r_key <= bus.key;
          r_round <= 4'd1;
          r_busy <= 1'b1;
        end
      end else if (r_round == 4'd10) begin
        r_cipher <= w_sr ^ w_nk;
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_round <= '0;
      end else begin
        r_state <= w_mc ^ w_nk;
        r_key <= w_nk;
        r_round <= r_round + 4'd1;
      end
    end
  end
  assign bus.cipher = r_cipher;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_aes128_encrypt.sv
// tb_aes128_encrypt: directed and randomized checks of aes128_encrypt against a byte-level AES reference
module tb_aes128_encrypt;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sbox [256];
  aes128_encrypt_if bus ();
  aes128_encrypt dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask
  function automatic logic [127:0] aes_ref(input logic [127:0] msg, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [176];
    logic [7:0] tmp [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = msg[127-8*i -: 8];
      w[i] = key[127-8*i -: 8];
    end
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox[w[4*(i-1)+(j+1)%4]];
        tmp[0] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] ^= w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sbox[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = rnd == 10 ? t[4*c+r] :
            gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] ^= w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask
  task automatic run(input string tag, input logic [127:0] msg, input logic [127:0] key, input logic [127:0] exp);
    int cyc;
    bus.message = msg;
    bus.key = key;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 128'(bus.busy), 128'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 128'(cyc), 128'd10);
    check({tag, "_cipher"}, bus.cipher, exp);
    tick();
    check({tag, "_done_once"}, 128'(bus.done), 128'd0);
  endtask
  initial begin
    int cyc;
    int pulses;
    logic [127:0] m, k, exp;
    bus.start = 1'b0;
    bus.message = '0;
    bus.key = '0;
    build_sbox();
    #2 rst = 1'b1;
    #1;
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_done", 128'(bus.done), 128'd0);
    check("reset_cipher", bus.cipher, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    run("kat027", 128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    run("kat028", 128'h54776F204F6E65204E696E652054776F, 128'h5468617473206D79204B756E67204675, 128'h29C3505F571420F6402299B31A02D73A);
    run("kat029", 128'h0, 128'h0, 128'h66E94BD4EF8A2C3B884CFA59CA342B2E);
    bus.message = 128'h00112233445566778899AABBCCDDEEFF;
    bus.key = 128'h000102030405060708090A0B0C0D0E0F;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.message = rnd128();
    bus.key = rnd128();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 4;
    while (bus.done !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("ignore_latency", 128'(cyc), 128'd10);
    check("ignore_cipher", bus.cipher, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("ignore_no_second_done", 128'(pulses), 128'd0);
    m = rnd128();
    k = rnd128();
    bus.message = m;
    bus.key = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_cipher", bus.cipher, 128'd0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_done", 128'(pulses), 128'd0);
    run("after_abort", 128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    m = rnd128();
    k = rnd128();
    exp = aes_ref(m, k);
    bus.message = m;
    bus.key = k;
    bus.start = 1'b1;
    tick();
    wait_done(cyc);
    check("stream_first_latency", 128'(cyc), 128'd10);
    check("stream_first_cipher", bus.cipher, exp);
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (bus.done !== 1'b1 && cyc < 30);
      check($sformatf("stream_period_%0d", p), 128'(cyc), 128'd11);
      check($sformatf("stream_cipher_%0d", p), bus.cipher, exp);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("stream_idle", 128'(bus.busy), 128'd0);
    for (int i = 0; i < 8; i++) begin
      m = rnd128();
      k = rnd128();
      run($sformatf("rand%0d", i), m, k, aes_ref(m, k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
